// File: rtl/simple_rx_mcdma_deadlock_pkg.sv
// Shared types and width helpers for the RX MCDMA deadlock monitor.
package simple_rx_mcdma_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DEADLOCK = 2'd2
    } state_e;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Source index width; the all-ones code is reserved for instance-caused deadlocks.
    function automatic int src_width(input int n_axis);
        int w;
        w = clog2_f(n_axis + 1);
        return (w > 1) ? w : 1;
    endfunction

endpackage

// File: rtl/simple_rx_mcdma_prio_enc.sv
// Lowest-index-first priority encoder over the AXIS stall inputs.
module simple_rx_mcdma_prio_enc
    import simple_rx_mcdma_deadlock_pkg::*;
#(
    parameter int N     = 1,
    parameter int IDX_W = src_width(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scanning downward lets the lowest asserted bit win.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/simple_rx_mcdma_deadlock_monitor.sv
// Watches AXIS and sub-instance stall signals and flags a deadlock once a stall persists THRESH cycles.
module simple_rx_mcdma_deadlock_monitor
    import simple_rx_mcdma_deadlock_pkg::*;
#(
    parameter int N_AXIS = 1,
    parameter int N_INST = 2,
    parameter int THRESH = 1,
    parameter int CNT_W  = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [N_AXIS-1:0]            axis_block_sigs,
    input  logic [N_INST-1:0]            inst_idle_sigs,
    input  logic [N_INST-1:0]            inst_block_sigs,
    input  logic                         clear,
    output logic                         block,
    output logic                         block_sticky,
    output logic [src_width(N_AXIS)-1:0] block_src,
    output logic [CNT_W-1:0]             block_cycles
);

    localparam int SRC_W  = src_width(N_AXIS);
    localparam int PCNT_W = clog2_f(THRESH + 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(THRESH - 1);

    logic              seq_block;
    logic [SRC_W-1:0]  enc_idx;
    logic              enc_valid;
    logic              entry;

    state_e            state_q, state_d;
    logic [PCNT_W-1:0] persist_cnt_q, persist_cnt_d;
    logic              block_sticky_q, block_sticky_d;
    logic [SRC_W-1:0]  block_src_q, block_src_d;
    logic [CNT_W-1:0]  block_cycles_q, block_cycles_d;

    simple_rx_mcdma_prio_enc #(
        .N     (N_AXIS),
        .IDX_W (SRC_W)
    ) u_prio_enc (
        .req   (axis_block_sigs),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Idle instances may legitimately hold their block line, so it is masked out.
    assign seq_block = (|axis_block_sigs) | (|(inst_block_sigs & ~inst_idle_sigs));

    always_comb begin
        state_d       = state_q;
        persist_cnt_d = persist_cnt_q;
        case (state_q)
            ST_IDLE: begin
                persist_cnt_d = '0;
                if (seq_block) begin
                    if (THRESH == 1) begin
                        state_d = ST_DEADLOCK;
                    end else begin
                        state_d       = ST_SUSPECT;
                        persist_cnt_d = PCNT_W'(1);
                    end
                end
            end
            ST_SUSPECT: begin
                if (!seq_block) begin
                    state_d       = ST_IDLE;
                    persist_cnt_d = '0;
                end else if (persist_cnt_q == PCNT_LAST) begin
                    state_d       = ST_DEADLOCK;
                    persist_cnt_d = '0;
                end else begin
                    persist_cnt_d = persist_cnt_q + PCNT_W'(1);
                end
            end
            ST_DEADLOCK: begin
                persist_cnt_d = '0;
                if (!seq_block) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                persist_cnt_d = '0;
            end
        endcase
    end

    // Source and sticky flag only move on the edge that enters DEADLOCK; set beats clear.
    always_comb begin
        entry          = (state_q != ST_DEADLOCK) && (state_d == ST_DEADLOCK);
        block_src_d    = block_src_q;
        block_sticky_d = block_sticky_q;
        block_cycles_d = block_cycles_q;
        if (entry) begin
            block_src_d = enc_valid ? enc_idx : '1;
        end
        if (entry) begin
            block_sticky_d = 1'b1;
        end else if (clear) begin
            block_sticky_d = 1'b0;
        end
        if (clear) begin
            block_cycles_d = '0;
        end else if ((state_q == ST_DEADLOCK) && (block_cycles_q != '1)) begin
            block_cycles_d = block_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            persist_cnt_q  <= '0;
            block_sticky_q <= 1'b0;
            block_src_q    <= '0;
            block_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            persist_cnt_q  <= persist_cnt_d;
            block_sticky_q <= block_sticky_d;
            block_src_q    <= block_src_d;
            block_cycles_q <= block_cycles_d;
        end
    end

    assign block        = (state_q == ST_DEADLOCK);
    assign block_sticky = block_sticky_q;
    assign block_src    = block_src_q;
    assign block_cycles = block_cycles_q;

endmodule

// File: tb/tb_simple_rx_mcdma_deadlock_monitor.sv
// Directed bench: dut_a uses THRESH=4/N_AXIS=4, dut_b uses THRESH=1/N_AXIS=1; both CNT_W=3.
module tb_simple_rx_mcdma_deadlock_monitor;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;

    logic [3:0] axis_a = '0;
    logic [1:0] idle_a = '0;
    logic [1:0] iblk_a = '0;
    logic       clear_a = 1'b0;
    logic       block_a, sticky_a;
    logic [2:0] src_a;
    logic [2:0] cycles_a;

    logic [0:0] axis_b = '0;
    logic [1:0] idle_b = '0;
    logic [1:0] iblk_b = '0;
    logic       clear_b = 1'b0;
    logic       block_b, sticky_b;
    logic [0:0] src_b;
    logic [2:0] cycles_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    simple_rx_mcdma_deadlock_monitor #(
        .N_AXIS (4), .N_INST (2), .THRESH (4), .CNT_W (3)
    ) dut_a (
        .clock           (clock),
        .reset_n         (reset_n),
        .axis_block_sigs (axis_a),
        .inst_idle_sigs  (idle_a),
        .inst_block_sigs (iblk_a),
        .clear           (clear_a),
        .block           (block_a),
        .block_sticky    (sticky_a),
        .block_src       (src_a),
        .block_cycles    (cycles_a)
    );

    simple_rx_mcdma_deadlock_monitor #(
        .N_AXIS (1), .N_INST (2), .THRESH (1), .CNT_W (3)
    ) dut_b (
        .clock           (clock),
        .reset_n         (reset_n),
        .axis_block_sigs (axis_b),
        .inst_idle_sigs  (idle_b),
        .inst_block_sigs (iblk_b),
        .clear           (clear_b),
        .block           (block_b),
        .block_sticky    (sticky_b),
        .block_src       (src_b),
        .block_cycles    (cycles_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (block_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_block_a got %0d exp 0", block_a); end
        checks++; if (sticky_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_sticky_a got %0d exp 0", sticky_a); end
        checks++; if (src_a !== 3'd0) begin errors++; $display("[TB] FAIL reset_src_a got %0d exp 0", src_a); end
        checks++; if (cycles_a !== 3'd0) begin errors++; $display("[TB] FAIL reset_cycles_a got %0d exp 0", cycles_a); end
        checks++; if (block_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_block_b got %0d exp 0", block_b); end
        checks++; if (sticky_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_sticky_b got %0d exp 0", sticky_b); end
        checks++; if (src_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_src_b got %0d exp 0", src_b); end
        checks++; if (cycles_b !== 3'd0) begin errors++; $display("[TB] FAIL reset_cycles_b got %0d exp 0", cycles_b); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_thresh1_entry();
        tick();
        checks++; if (block_b !== 1'b0) begin errors++; $display("[TB] FAIL t1_quiet_block got %0d exp 0", block_b); end
        axis_b = 1'b1;
        tick();
        checks++; if (block_b !== 1'b1) begin errors++; $display("[TB] FAIL t1_entry_block got %0d exp 1", block_b); end
        checks++; if (src_b !== 1'b0) begin errors++; $display("[TB] FAIL t1_entry_src got %0d exp 0", src_b); end
        checks++; if (sticky_b !== 1'b1) begin errors++; $display("[TB] FAIL t1_entry_sticky got %0d exp 1", sticky_b); end
        tick();
        checks++; if (cycles_b !== 3'd1) begin errors++; $display("[TB] FAIL t1_cycles got %0d exp 1", cycles_b); end
        axis_b = 1'b0;
        tick();
        checks++; if (block_b !== 1'b0) begin errors++; $display("[TB] FAIL t1_release_block got %0d exp 0", block_b); end
        checks++; if (sticky_b !== 1'b1) begin errors++; $display("[TB] FAIL t1_release_sticky got %0d exp 1", sticky_b); end
    endtask

    task automatic test_glitch();
        axis_a = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (block_a !== 1'b0) begin errors++; $display("[TB] FAIL glitch_block[%0d] got %0d exp 0", i, block_a); end
            checks++; if (sticky_a !== 1'b0) begin errors++; $display("[TB] FAIL glitch_sticky[%0d] got %0d exp 0", i, sticky_a); end
        end
        axis_a = 4'b0000;
        tick();
        checks++; if (block_a !== 1'b0) begin errors++; $display("[TB] FAIL glitch_end_block got %0d exp 0", block_a); end
        checks++; if (sticky_a !== 1'b0) begin errors++; $display("[TB] FAIL glitch_end_sticky got %0d exp 0", sticky_a); end
    endtask

    task automatic test_persist_and_saturate();
        axis_a = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (block_a !== 1'b0) begin errors++; $display("[TB] FAIL persist_block[%0d] got %0d exp 0", i, block_a); end
        end
        tick();
        checks++; if (block_a !== 1'b1) begin errors++; $display("[TB] FAIL persist_entry_block got %0d exp 1", block_a); end
        checks++; if (src_a !== 3'd2) begin errors++; $display("[TB] FAIL persist_entry_src got %0d exp 2", src_a); end
        checks++; if (sticky_a !== 1'b1) begin errors++; $display("[TB] FAIL persist_entry_sticky got %0d exp 1", sticky_a); end
        checks++; if (cycles_a !== 3'd0) begin errors++; $display("[TB] FAIL persist_entry_cycles got %0d exp 0", cycles_a); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (cycles_a !== 3'd3) begin errors++; $display("[TB] FAIL cycles_mid got %0d exp 3", cycles_a); end
        for (int i = 0; i < 7; i++) tick();
        checks++; if (cycles_a !== 3'd7) begin errors++; $display("[TB] FAIL cycles_saturate got %0d exp 7", cycles_a); end
        axis_a = 4'b0000;
        tick();
        checks++; if (block_a !== 1'b0) begin errors++; $display("[TB] FAIL release_block_a got %0d exp 0", block_a); end
        checks++; if (cycles_a !== 3'd7) begin errors++; $display("[TB] FAIL release_cycles_a got %0d exp 7", cycles_a); end
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        checks++; if (cycles_a !== 3'd0) begin errors++; $display("[TB] FAIL clear_cycles_a got %0d exp 0", cycles_a); end
        checks++; if (sticky_a !== 1'b0) begin errors++; $display("[TB] FAIL clear_sticky_a got %0d exp 0", sticky_a); end
    endtask

    task automatic test_inst_idle();
        iblk_a = 2'b01;
        idle_a = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (block_a !== 1'b0) begin errors++; $display("[TB] FAIL idle_masked_block got %0d exp 0", block_a); end
        checks++; if (sticky_a !== 1'b0) begin errors++; $display("[TB] FAIL idle_masked_sticky got %0d exp 0", sticky_a); end
        idle_a = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (block_a !== 1'b0) begin errors++; $display("[TB] FAIL inst_early_block got %0d exp 0", block_a); end
        tick();
        checks++; if (block_a !== 1'b1) begin errors++; $display("[TB] FAIL inst_entry_block got %0d exp 1", block_a); end
        checks++; if (src_a !== 3'd7) begin errors++; $display("[TB] FAIL inst_entry_src got %0d exp 7", src_a); end
        iblk_a = 2'b00;
        tick();
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
    endtask

    task automatic test_clear_at_entry();
        clear_b = 1'b1;
        tick();
        checks++; if (sticky_b !== 1'b0) begin errors++; $display("[TB] FAIL pre_clear_sticky_b got %0d exp 0", sticky_b); end
        checks++; if (cycles_b !== 3'd0) begin errors++; $display("[TB] FAIL pre_clear_cycles_b got %0d exp 0", cycles_b); end
        axis_b = 1'b1;
        tick();
        clear_b = 1'b0;
        checks++; if (block_b !== 1'b1) begin errors++; $display("[TB] FAIL clr_entry_block got %0d exp 1", block_b); end
        checks++; if (sticky_b !== 1'b1) begin errors++; $display("[TB] FAIL clr_entry_sticky got %0d exp 1", sticky_b); end
        checks++; if (cycles_b !== 3'd0) begin errors++; $display("[TB] FAIL clr_entry_cycles got %0d exp 0", cycles_b); end
        tick();
        checks++; if (cycles_b !== 3'd1) begin errors++; $display("[TB] FAIL clr_after_cycles got %0d exp 1", cycles_b); end
        axis_b = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        axis_a = 4'b0100;
        axis_b = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (block_a !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_block_a got %0d exp 1", block_a); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (block_a !== 1'b0) begin errors++; $display("[TB] FAIL async_block_a got %0d exp 0", block_a); end
        checks++; if (sticky_a !== 1'b0) begin errors++; $display("[TB] FAIL async_sticky_a got %0d exp 0", sticky_a); end
        checks++; if (block_b !== 1'b0) begin errors++; $display("[TB] FAIL async_block_b got %0d exp 0", block_b); end
        checks++; if (sticky_b !== 1'b0) begin errors++; $display("[TB] FAIL async_sticky_b got %0d exp 0", sticky_b); end
        checks++; if (cycles_b !== 3'd0) begin errors++; $display("[TB] FAIL async_cycles_b got %0d exp 0", cycles_b); end
        #1;
        reset_n = 1'b1;
        tick();
        checks++; if (block_b !== 1'b1) begin errors++; $display("[TB] FAIL redetect_block_b got %0d exp 1", block_b); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (block_a !== 1'b0) begin errors++; $display("[TB] FAIL redetect_early_a[%0d] got %0d exp 0", i, block_a); end
            tick();
        end
        checks++; if (block_a !== 1'b0) begin errors++; $display("[TB] FAIL redetect_early_a[2] got %0d exp 0", block_a); end
        tick();
        checks++; if (block_a !== 1'b1) begin errors++; $display("[TB] FAIL redetect_block_a got %0d exp 1", block_a); end
        checks++; if (src_a !== 3'd2) begin errors++; $display("[TB] FAIL redetect_src_a got %0d exp 2", src_a); end
        axis_a = 4'b0000;
        axis_b = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_thresh1_entry();
        test_glitch();
        test_persist_and_saturate();
        test_inst_idle();
        test_clear_at_entry();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
